register_file_mp: RTL and testbench

Parametrised successor to the pipeline register file.
- Adds configurable read-port count, a hardwired zero register, optional write-to-read bypass and an asynchronous clear.
- Adds a handshaked debug dump engine that streams every register, address 0 to RAM_DEPTH-1, to the debug unit.
- Sits in the decode stage of the pipelined processor; the dump port connects to the debug/UART unit.

---
 rtl/register_file_mp_pkg.sv | 38 +++
 rtl/register_file_mp_dump_ctrl.sv | 85 ++++++++
 rtl/register_file_mp.sv | 87 ++++++++
 tb/tb_register_file_mp.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/register_file_mp_pkg.sv
// register_file_mp_pkg: shared dump FSM encoding and read-source priority for register_file_mp
// Contents:
//   dump_state_t - dump FSM states (IDLE=0, LOAD=1, SEND=2, DONE=3)
//   read_src_t   - where a read port takes its value from
//   write_ok     - whether a write strobe actually lands in the array
//   read_src     - zero-register / bypass / range priority shared by read ports and the dump LOAD
package register_file_mp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } dump_state_t;

    typedef enum logic [1:0] {
        SRC_ZERO   = 2'd0,
        SRC_BYPASS = 2'd1,
        SRC_ARRAY  = 2'd2
    } read_src_t;

    function automatic logic write_ok(input int unsigned waddr, input logic we,
                                      input int unsigned depth, input int zero_reg);
        return we && !(zero_reg != 0 && waddr == 0) && waddr < depth;
    endfunction

    // The zero register beats bypass so r0 can never leak write data; bypass beats the
    // range check, which cannot conflict because a dropped write never bypasses.
    function automatic read_src_t read_src(input int unsigned addr, input int unsigned waddr,
                                           input int unsigned depth, input logic we,
                                           input int zero_reg, input int bypass);
        return (zero_reg != 0 && addr == 0) ? SRC_ZERO
             : (bypass != 0 && write_ok(waddr, we, depth, zero_reg) && addr == waddr) ? SRC_BYPASS
             : (addr >= depth) ? SRC_ZERO
             : SRC_ARRAY;
    endfunction

endpackage

// File: rtl/register_file_mp_dump_ctrl.sv
// regfile_dump_ctrl: handshaked engine that streams registers 0..RAM_DEPTH-1 to the debug unit
// Ports:
//   clock, reset     - rising-edge clock, asynchronous active-high reset
//   start            - single-cycle dump request, honoured only while idle
//   ready            - consumer ready
//   rd_data          - array value for rd_addr, already through the read priority mux
//   rd_addr          - dump pointer driven onto the internal read port
//   valid/addr/data  - registered dump word, held stable while ready is low
//   done             - one-cycle pulse after the last word is accepted
//   busy             - high whenever the FSM is not idle
module regfile_dump_ctrl
    import register_file_mp_pkg::*;
#(
    parameter int NB_ADDR   = 5,
    parameter int NB_DATA   = 32,
    parameter int RAM_DEPTH = 2**NB_ADDR
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               ready,
    input  logic [NB_DATA-1:0] rd_data,
    output logic [NB_ADDR-1:0] rd_addr,
    output logic               valid,
    output logic [NB_ADDR-1:0] addr,
    output logic [NB_DATA-1:0] data,
    output logic               done,
    output logic               busy
);

    localparam int PW = $clog2(RAM_DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(RAM_DEPTH - 1);

    dump_state_t   state;
    logic [PW-1:0] ptr;

    assign rd_addr = NB_ADDR'(ptr);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            ptr   <= '0;
            valid <= 1'b0;
            addr  <= '0;
            data  <= '0;
            done  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        ptr   <= '0;
                        busy  <= 1'b1;
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    addr  <= rd_addr;
                    data  <= rd_data;
                    valid <= 1'b1;
                    state <= ST_SEND;
                end
                ST_SEND: begin
                    if (ready) begin
                        valid <= 1'b0;
                        if (ptr == LAST) begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            ptr   <= ptr + PW'(1);
                            state <= ST_LOAD;
                        end
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/register_file_mp.sv
// register_file_mp: multi-port decode-stage register file with zero register, bypass and debug dump
// Ports:
//   i_clock, i_reset                   - rising-edge clock, asynchronous active-high reset
//   i_write_enable/i_write_addr/i_data - single write port
//   i_read_addr/o_read_data            - N_READ combinational read ports, port k in slice k
//   i_dump_start/i_dump_ready          - dump request and consumer ready
//   o_dump_valid/addr/data/done        - dump word stream and completion pulse
//   o_busy                             - dump engine active
module register_file_mp
    import register_file_mp_pkg::*;
#(
    parameter int NB_ADDR   = 5,
    parameter int NB_DATA   = 32,
    parameter int RAM_DEPTH = 2**NB_ADDR,
    parameter int N_READ    = 2,
    parameter int ZERO_REG  = 1,
    parameter int BYPASS    = 1
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_write_enable,
    input  logic [NB_ADDR-1:0]        i_write_addr,
    input  logic [NB_DATA-1:0]        i_data,
    input  logic [N_READ*NB_ADDR-1:0] i_read_addr,
    output logic [N_READ*NB_DATA-1:0] o_read_data,
    input  logic                      i_dump_start,
    input  logic                      i_dump_ready,
    output logic                      o_dump_valid,
    output logic [NB_ADDR-1:0]        o_dump_addr,
    output logic [NB_DATA-1:0]        o_dump_data,
    output logic                      o_dump_done,
    output logic                      o_busy
);

    // Storage spans the whole address space so any address indexes it directly; slots at or
    // above RAM_DEPTH are never written and stay zero, so synthesis folds them away.
    localparam int SLOTS = 2**NB_ADDR;

    logic [NB_DATA-1:0] regs [SLOTS];
    logic               wr_ok;
    logic [NB_ADDR-1:0] dump_ptr;
    logic [NB_DATA-1:0] dump_rd;

    assign wr_ok = write_ok(32'(i_write_addr), i_write_enable, RAM_DEPTH, ZERO_REG);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < SLOTS; i++) regs[i] <= '0;
        end else if (wr_ok) begin
            regs[i_write_addr] <= i_data;
        end
    end

    function automatic logic [NB_DATA-1:0] read_value(input logic [NB_ADDR-1:0] a);
        read_src_t src;
        src = read_src(32'(a), 32'(i_write_addr), RAM_DEPTH, i_write_enable, ZERO_REG, BYPASS);
        return src == SRC_BYPASS ? i_data : src == SRC_ARRAY ? regs[a] : '0;
    endfunction

    always_comb begin
        o_read_data = '0;
        for (int k = 0; k < N_READ; k++)
            o_read_data[k*NB_DATA +: NB_DATA] = read_value(i_read_addr[k*NB_ADDR +: NB_ADDR]);
    end

    // Extra internal read port for the dump engine, with the same bypass behaviour as the others.
    assign dump_rd = read_value(dump_ptr);

    regfile_dump_ctrl #(
        .NB_ADDR  (NB_ADDR),
        .NB_DATA  (NB_DATA),
        .RAM_DEPTH(RAM_DEPTH)
    ) u_dump (
        .clock  (i_clock),
        .reset  (i_reset),
        .start  (i_dump_start),
        .ready  (i_dump_ready),
        .rd_data(dump_rd),
        .rd_addr(dump_ptr),
        .valid  (o_dump_valid),
        .addr   (o_dump_addr),
        .data   (o_dump_data),
        .done   (o_dump_done),
        .busy   (o_busy)
    );

endmodule

// File: tb/tb_register_file_mp.sv
// tb_register_file_mp: self-checking bench for register_file_mp (default build plus a ZERO_REG=0/BYPASS=0/24-deep build)
module tb_register_file_mp;

    logic        clk = 1'b0;
    logic        rst, we, start, ready;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [9:0]  ra;
    logic [63:0] rd_a, rd_b;
    logic        va, vb, da, db, ba, bb;
    logic [4:0]  aa, ab;
    logic [31:0] dta, dtb;

    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] mem_a [32];
    logic [31:0] mem_b [32];

    register_file_mp dut_a (
        .i_clock(clk), .i_reset(rst), .i_write_enable(we), .i_write_addr(wa), .i_data(wd),
        .i_read_addr(ra), .o_read_data(rd_a), .i_dump_start(start), .i_dump_ready(ready),
        .o_dump_valid(va), .o_dump_addr(aa), .o_dump_data(dta), .o_dump_done(da), .o_busy(ba)
    );

    register_file_mp #(.RAM_DEPTH(24), .ZERO_REG(0), .BYPASS(0)) dut_b (
        .i_clock(clk), .i_reset(rst), .i_write_enable(we), .i_write_addr(wa), .i_data(wd),
        .i_read_addr(ra), .o_read_data(rd_b), .i_dump_start(start), .i_dump_ready(ready),
        .o_dump_valid(vb), .o_dump_addr(ab), .o_dump_data(dtb), .o_dump_done(db), .o_busy(bb)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: b selects the 24-deep build without zero register or bypass.
    function automatic logic [31:0] model_rd(input bit b, input int a);
        int depth;
        bit zr, ok;
        depth = b ? 24 : 32;
        zr = !b;
        ok = we && !(zr && wa == 0) && int'(wa) < depth;
        if (zr && a == 0) return 32'h0;
        if (!b && ok && a == int'(wa)) return wd;
        if (a >= depth) return 32'h0;
        return b ? mem_b[a] : mem_a[a];
    endfunction

    task automatic model_write();
        if (we && wa != 0) mem_a[wa] = wd;
        if (we && wa < 24) mem_b[wa] = wd;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) begin
            mem_a[i] = 32'h0;
            mem_b[i] = 32'h0;
        end
    endtask

    task automatic cycle();
        model_write();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reads();
        for (int p = 0; p < 2; p++) begin
            chk($sformatf("rd_a port%0d addr%0d", p, ra[p*5 +: 5]), rd_a[p*32 +: 32], model_rd(1'b0, int'(ra[p*5 +: 5])));
            chk($sformatf("rd_b port%0d addr%0d", p, ra[p*5 +: 5]), rd_b[p*32 +: 32], model_rd(1'b1, int'(ra[p*5 +: 5])));
        end
    endtask

    // Runs one dump with ready high apart from an optional 5-cycle stall on word stall_at.
    // Word data is checked against i*16 (preloaded pattern) or against the model.
    task automatic run_dump(input bit use_model, input int stall_at,
                            output int first_c, output int words, output int done_c, output int bdone_c);
        int cyc;
        bit stalled;
        cyc = 0; words = 0; first_c = -1; done_c = -1; bdone_c = -1; stalled = 0;
        ready = 1'b1;
        start = 1'b1;
        while (cyc < 300 && done_c < 0) begin
            @(posedge clk);
            #1;
            cyc++;
            start = 1'b0;
            if (va) begin
                if (first_c < 0) first_c = cyc;
                chk($sformatf("dump addr word%0d", words), 32'(aa), 32'(words));
                chk($sformatf("dump data word%0d", words), dta, use_model ? mem_a[words] : 32'(words * 16));
                if (words == stall_at && !stalled) begin
                    stalled = 1;
                    ready = 1'b0;
                    we = 1'b1; wa = 5'(stall_at); wd = 32'hAA;
                    for (int s = 0; s < 5; s++) begin
                        model_write();
                        @(posedge clk);
                        #1;
                        cyc++;
                        we = 1'b0;
                        chk($sformatf("stall valid s%0d", s), 32'(va), 32'd1);
                        chk($sformatf("stall addr s%0d", s), 32'(aa), 32'(stall_at));
                        chk($sformatf("stall data s%0d", s), dta, 32'(stall_at * 16));
                    end
                    ready = 1'b1;
                end
                words++;
            end
            if (db && bdone_c < 0) bdone_c = cyc;
            if (da) begin
                done_c = cyc;
                chk("busy during done", 32'(ba), 32'd1);
            end
        end
        if (done_c < 0) chk("dump timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        chk("busy after done", 32'(ba), 32'd0);
        chk("done one pulse", 32'(da), 32'd0);
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  r0, r1;
        logic [31:0] a0, a1, b0, b1;
    } vec_t;

    vec_t tbl [10];
    int first_c, words, done_c, bdone_c, hits, nd;

    initial begin
        rst = 1'b1; we = 1'b0; wa = '0; wd = '0; ra = '0; start = 1'b0; ready = 1'b1;
        clear_model();
        tbl[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd3,  32'hDEADBEEF, 32'h0, 32'h0, 32'h0};
        tbl[1] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd0,  32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0};
        tbl[2] = '{1'b1, 5'd0,  32'h1234,     5'd0,  5'd5,  32'h0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF};
        tbl[3] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0, 32'h0, 32'h1234, 32'h1234};
        tbl[4] = '{1'b1, 5'd7,  32'h11,       5'd7,  5'd3,  32'h11, 32'h0, 32'h0, 32'h0};
        tbl[5] = '{1'b1, 5'd7,  32'h22,       5'd7,  5'd3,  32'h22, 32'h0, 32'h11, 32'h0};
        tbl[6] = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd5,  32'h22, 32'hDEADBEEF, 32'h22, 32'hDEADBEEF};
        tbl[7] = '{1'b1, 5'd28, 32'hCAFE,     5'd28, 5'd7,  32'hCAFE, 32'h22, 32'h0, 32'h22};
        tbl[8] = '{1'b0, 5'd0,  32'h0,        5'd28, 5'd31, 32'hCAFE, 32'h0, 32'h0, 32'h0};
        tbl[9] = '{1'b1, 5'd3,  32'h33,       5'd3,  5'd3,  32'h33, 32'h33, 32'h0, 32'h0};
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        repeat (20) begin
            we = 1'b1; wa = 5'($urandom); wd = $urandom; ra = {5'($urandom), 5'($urandom)};
            @(negedge clk);
            check_reads();
            cycle();
        end
        we = 1'b0; ra = {5'd9, 5'd5};
        #2;
        rst = 1'b1;
        #1;
        clear_model();
        chk("reset rd_a p0", rd_a[31:0], 32'h0);
        chk("reset rd_a p1", rd_a[63:32], 32'h0);
        chk("reset rd_b p0", rd_b[31:0], 32'h0);
        chk("reset valid", 32'(va), 32'd0);
        chk("reset busy", 32'(ba), 32'd0);
        chk("reset done", 32'(da), 32'd0);
        chk("reset dump addr", 32'(aa), 32'd0);
        chk("reset dump data", dta, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            we = tbl[i].we; wa = tbl[i].wa; wd = tbl[i].wd; ra = {tbl[i].r1, tbl[i].r0};
            @(negedge clk);
            chk($sformatf("vec%0d a p0", i), rd_a[31:0],  tbl[i].a0);
            chk($sformatf("vec%0d a p1", i), rd_a[63:32], tbl[i].a1);
            chk($sformatf("vec%0d b p0", i), rd_b[31:0],  tbl[i].b0);
            chk($sformatf("vec%0d b p1", i), rd_b[63:32], tbl[i].b1);
            cycle();
        end

        repeat (300) begin
            we = 1'($urandom); wa = 5'($urandom); wd = $urandom;
            ra = {5'($urandom), ($urandom_range(0, 3) == 0) ? wa : 5'($urandom)};
            @(negedge clk);
            check_reads();
            cycle();
        end

        for (int i = 0; i < 32; i++) begin
            we = 1'b1; wa = 5'(i); wd = 32'(i * 16);
            cycle();
        end
        we = 1'b0;
        run_dump(1'b0, -1, first_c, words, done_c, bdone_c);
        chk("full first valid cycle", 32'(first_c), 32'd2);
        chk("full word count", 32'(words), 32'd32);
        chk("full done cycle", 32'(done_c), 32'd65);
        chk("full done cycle depth24", 32'(bdone_c), 32'd49);

        run_dump(1'b0, 4, first_c, words, done_c, bdone_c);
        chk("stall word count", 32'(words), 32'd32);
        chk("stall done cycle", 32'(done_c), 32'd70);
        ra = {5'd4, 5'd4};
        @(negedge clk);
        check_reads();

        start = 1'b1; hits = 0;
        for (int c = 0; c < 100 && hits == 0; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (va && aa == 5'd10) hits = 1;
        end
        chk("abort reached r10", 32'(hits), 32'd1);
        ra = {5'd10, 5'd4};
        #2;
        rst = 1'b1;
        #1;
        clear_model();
        chk("abort valid", 32'(va), 32'd0);
        chk("abort busy", 32'(ba), 32'd0);
        chk("abort addr", 32'(aa), 32'd0);
        check_reads();
        @(posedge clk);
        #1;
        rst = 1'b0;
        nd = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (da || ba) nd++;
        end
        chk("abort no done", 32'(nd), 32'd0);
        we = 1'b1; wa = 5'd1; wd = 32'h77;
        cycle();
        we = 1'b0;
        run_dump(1'b1, -1, first_c, words, done_c, bdone_c);
        chk("restart first valid cycle", 32'(first_c), 32'd2);
        chk("restart word count", 32'(words), 32'd32);
        chk("restart done cycle", 32'(done_c), 32'd65);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
